psum_ofifo: RTL and testbench

//  Output collection stage directly downstream of the MAC array. Captures the per-column partial sums
//  (out_s) whenever the array asserts the matching column's valid bit, buffering each column in its own FIFO.

---
 rtl/psum_ofifo.sv | 85 ++++++++
 tb/tb_psum_ofifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_ofifo.sv
// Per-column partial-sum FIFOs behind the MAC array; realigns independently finishing columns
// into full rows that are popped together with a single read strobe (first-word-fall-through).
module psum_ofifo #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_ovf
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned PW = AW + 1;

    logic [col-1:0] empty_c;
    logic [col-1:0] full_c;
    logic           rd_en_c;
    logic           ovf_d;
    logic           ovf_q;

    // A row is poppable only once every column holds at least one entry.
    assign o_valid = &(~empty_c);
    assign o_full  = |full_c;
    assign o_ready = ~o_full;
    assign rd_en_c = rd & o_valid;
    assign o_ovf   = ovf_q;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [psum_bw-1:0] mem_q [depth];
        logic [PW-1:0]      wr_ptr_q;
        logic [PW-1:0]      wr_ptr_d;
        logic [PW-1:0]      rd_ptr_q;
        logic [PW-1:0]      rd_ptr_d;
        logic               wr_en_c;

        // Extra wrap bit distinguishes full from empty when the index bits match.
        assign empty_c[c] = (wr_ptr_q == rd_ptr_q);
        assign full_c[c]  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign wr_en_c    = wr[c] & ~full_c[c];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en_c) rd_ptr_d = rd_ptr_q + PW'(1);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        // Storage is intentionally not reset; pointers alone define validity.
        always_ff @(posedge clk) begin
            if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= in[c*psum_bw +: psum_bw];
        end

        assign out[c*psum_bw +: psum_bw] = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Sticky overflow: any strobe into a column that was full before the edge.
    always_comb begin
        ovf_d = ovf_q | (|(wr & full_c));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: queue-based reference model compared every cycle, directed scenarios with
// literal expectations, and a randomized phase.
module tb_psum_ofifo;

    localparam int unsigned COL   = 8;
    localparam int unsigned PBW   = 16;
    localparam int unsigned DEPTH = 64;

    logic               clk;
    logic               reset;
    logic [PBW*COL-1:0] in;
    logic [COL-1:0]     wr;
    logic               rd;
    logic [PBW*COL-1:0] out;
    logic               o_valid, o_full, o_ready, o_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    logic [PBW-1:0] mq [COL][$];
    bit             m_ovf;

    psum_ofifo #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
        .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_ovf(o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_valid();
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: FIFO queues per column, decisions taken on pre-edge occupancy.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            m_ovf = 1'b0;
        end else begin
            bit v;
            bit fl [COL];
            v = m_valid();
            for (int c = 0; c < COL; c++) fl[c] = (mq[c].size() == DEPTH);
            if (rd && v) for (int c = 0; c < COL; c++) void'(mq[c].pop_front());
            for (int c = 0; c < COL; c++) begin
                if (wr[c]) begin
                    if (fl[c]) m_ovf = 1'b1;
                    else mq[c].push_back(in[c*PBW +: PBW]);
                end
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en && reset) begin
            bit mv;
            mv = m_valid();
            chk("o_valid", 128'(o_valid), 128'(mv));
            chk("o_full",  128'(o_full),  128'(m_full()));
            chk("o_ready", 128'(o_ready), 128'(!m_full()));
            chk("o_ovf",   128'(o_ovf),   128'(m_ovf));
            if (mv) begin
                for (int c = 0; c < COL; c++)
                    chk("out_col", 128'(out[c*PBW +: PBW]), 128'(mq[c][0]));
            end
        end
    end

    task automatic cyc(input logic [COL-1:0] w, input logic [PBW*COL-1:0] d, input logic r);
        wr = w;
        in = d;
        rd = r;
        @(negedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    function automatic logic [PBW*COL-1:0] rnd_row();
        logic [PBW*COL-1:0] v;
        for (int c = 0; c < COL; c++) v[c*PBW +: PBW] = PBW'($urandom);
        return v;
    endfunction

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        chk("rst_async_valid", 128'(o_valid), 128'(0));
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [PBW*COL-1:0] row;
        logic [PBW*COL-1:0] exp_row;
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        in    = '0;

        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_full",  128'(o_full),  128'(0));
        chk("rst_ready", 128'(o_ready), 128'(1));
        chk("rst_ovf",   128'(o_ovf),   128'(0));
        chk_en = 1'b1;

        // 2: skewed fill
        exp_row = '0;
        for (int c = 0; c < COL; c++) begin
            row = '0;
            row[c*PBW +: PBW] = PBW'(16'h0100 + c);
            exp_row[c*PBW +: PBW] = PBW'(16'h0100 + c);
            cyc(COL'(1) << c, row, 1'b0);
            chk("skew_valid", 128'(o_valid), 128'(c == COL - 1));
        end
        chk("skew_row", 128'(out), 128'(exp_row));
        cyc('0, '0, 1'b1);
        chk("skew_pop_valid", 128'(o_valid), 128'(0));

        // 3: fill column 0 to full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            row = '0;
            row[PBW-1:0] = PBW'(i);
            cyc(COL'(1), row, 1'b0);
            if (i == DEPTH - 2) chk("col0_not_full", 128'(o_full), 128'(0));
        end
        chk("col0_full",  128'(o_full),  128'(1));
        chk("col0_ready", 128'(o_ready), 128'(0));
        row = '0;
        row[PBW-1:0] = PBW'(99);
        cyc(COL'(1), row, 1'b0);
        chk("col0_ovf", 128'(o_ovf), 128'(1));
        for (int i = 0; i < DEPTH; i++) cyc(~COL'(1), rnd_row(), 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("col0_order", 128'(out[PBW-1:0]), 128'(i));
            cyc('0, '0, 1'b1);
        end
        chk("col0_drained", 128'(o_valid), 128'(0));
        pulse_reset();
        chk("ovf_cleared", 128'(o_ovf), 128'(0));

        // 4: wrap-around over three passes
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 40; i++) cyc('1, rnd_row(), 1'b0);
            for (int i = 0; i < 40; i++) cyc('0, '0, 1'b1);
        end
        chk("wrap_ovf",   128'(o_ovf),   128'(0));
        chk("wrap_empty", 128'(o_valid), 128'(0));

        // 5: concurrent read and write at steady occupancy
        for (int i = 0; i < 5; i++) cyc('1, rnd_row(), 1'b0);
        for (int i = 0; i < 10; i++) cyc('1, rnd_row(), 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("conc_occ_valid", 128'(o_valid), 128'(1));
            cyc('0, '0, 1'b1);
        end
        chk("conc_occ_empty", 128'(o_valid), 128'(0));

        // 6: reset mid-operation
        for (int i = 0; i < 10; i++) cyc('1, rnd_row(), 1'b0);
        chk("pre_rst_valid", 128'(o_valid), 128'(1));
        pulse_reset();
        cyc('1, {COL{16'hBEEF}}, 1'b0);
        chk("post_rst_valid", 128'(o_valid), 128'(1));
        chk("post_rst_row",   128'(out), 128'({COL{16'hBEEF}}));
        cyc('0, '0, 1'b1);
        chk("post_rst_empty", 128'(o_valid), 128'(0));

        // Randomized traffic, including rd while empty and writes to full columns
        for (int i = 0; i < 600; i++) begin
            logic [COL-1:0] w;
            w = COL'($urandom) & COL'($urandom);
            if (i >= 300) w = COL'($urandom);
            cyc(w, rnd_row(), 1'($urandom_range(0, (i >= 300) ? 3 : 1) == 0));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
